// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the fetch-stage aligner: the NOP filler word,
// line/halfword geometry, the replacement FSM encoding, the lookup result
// record returned by the line buffer, and small halfword helpers.
package fetch_pkg;

    // Instruction driven whenever nothing real is available (addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Line tag covers address bits [31:3]
    localparam int LINE_AW = 29;

    // An 8-byte line holds four halfwords
    localparam int HW_IDX_W = 2;
    localparam int LINE_W   = 64;

    // Replacement FSM: EMPTY (nothing valid), ONE (CUR only), TWO (CUR+PRV)
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } bufState_e;

    // Result of one tag lookup into the line buffer
    typedef struct packed {
        logic              hit;
        logic [LINE_W-1:0] data;
    } lookupRes_t;

    // A halfword starts a compressed instruction unless its low bits are 11
    function automatic logic isRvc(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

    // Pick halfword idx out of a line (halfword k = bits [16k+15:16k])
    function automatic logic [15:0] getHalf(input logic [LINE_W-1:0] line,
                                            input logic [HW_IDX_W-1:0] idx);
        logic [15:0] hw;
        case (idx)
            2'd0:    hw = line[15:0];
            2'd1:    hw = line[31:16];
            2'd2:    hw = line[47:32];
            default: hw = line[63:48];
        endcase
        return hw;
    endfunction

endpackage

// File: rtl/fetch_align_if.sv
// fetch_align_if
// Instruction-SRAM read-return bus feeding the fetch aligner.
//   isram_cs_ff     : rdata/rdata_adr valid this cycle (read issued last cycle)
//   isram_rdata     : returned 64-bit line
//   isram_rdata_adr : line address [31:3] of isram_rdata
// master = SRAM return side (drives), slave = aligner (receives).
interface fetch_align_if;
    import fetch_pkg::*;

    logic               isram_cs_ff;
    logic [LINE_W-1:0]  isram_rdata;
    logic [LINE_AW-1:0] isram_rdata_adr;

    modport master (
        output isram_cs_ff,
        output isram_rdata,
        output isram_rdata_adr
    );

    modport slave (
        input isram_cs_ff,
        input isram_rdata,
        input isram_rdata_adr
    );

endinterface

// File: rtl/fetch_line_buf.sv
// fetch_line_buf
// Two-entry tagged line buffer (CUR = most recent line, PRV = the one before)
// with a small replacement FSM and a kill that invalidates both entries.
// Ports:
//   clk, cpurst_n          : clock, async active-low reset
//   capEn_i                : capture a returned line this cycle
//   capTag_i, capData_i    : tag and data of the returned line
//   kill_i                 : invalidate both entries (wins over capture)
//   lookupTagA_i/lookupA_o : first tag lookup, CUR has priority on a double hit
//   lookupTagB_i/lookupB_o : second tag lookup, same rules
module fetch_line_buf
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               cpurst_n,
    input  logic               capEn_i,
    input  logic [LINE_AW-1:0] capTag_i,
    input  logic [LINE_W-1:0]  capData_i,
    input  logic               kill_i,
    input  logic [LINE_AW-1:0] lookupTagA_i,
    output lookupRes_t         lookupA_o,
    input  logic [LINE_AW-1:0] lookupTagB_i,
    output lookupRes_t         lookupB_o
);

    bufState_e          state_q, state_d;
    logic [LINE_AW-1:0] curTag_q, curTag_d;
    logic [LINE_AW-1:0] prvTag_q, prvTag_d;
    logic [LINE_W-1:0]  curData_q, curData_d;
    logic [LINE_W-1:0]  prvData_q, prvData_d;

    logic curVld;
    logic prvVld;
    logic sameTag;

    // The valid bits are exactly what the FSM state encodes, so they are
    // decoded from it rather than stored separately and risking disagreement.
    assign curVld  = (state_q != EMPTY);
    assign prvVld  = (state_q == TWO);
    assign sameTag = curVld && (capTag_i == curTag_q);

    // Next-state and next-contents: a re-read of the CUR line only refreshes
    // its data, any other line shifts CUR into PRV; kill discards everything.
    always_comb begin
        state_d   = state_q;
        curTag_d  = curTag_q;
        prvTag_d  = prvTag_q;
        curData_d = curData_q;
        prvData_d = prvData_q;
        if (kill_i) begin
            state_d = EMPTY;
        end else if (capEn_i) begin
            if (sameTag) begin
                curData_d = capData_i;
            end else begin
                prvTag_d  = curTag_q;
                prvData_d = curData_q;
                curTag_d  = capTag_i;
                curData_d = capData_i;
                case (state_q)
                    EMPTY:   state_d = ONE;
                    ONE:     state_d = TWO;
                    TWO:     state_d = TWO;
                    default: state_d = ONE;
                endcase
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Tag and data storage for both entries
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            curTag_q  <= '0;
            prvTag_q  <= '0;
            curData_q <= '0;
            prvData_q <= '0;
        end else begin
            curTag_q  <= curTag_d;
            prvTag_q  <= prvTag_d;
            curData_q <= curData_d;
            prvData_q <= prvData_d;
        end
    end

    // Two independent lookups; CUR wins when both entries match
    always_comb begin
        lookupA_o.hit  = 1'b0;
        lookupA_o.data = '0;
        if (curVld && (curTag_q == lookupTagA_i)) begin
            lookupA_o.hit  = 1'b1;
            lookupA_o.data = curData_q;
        end else if (prvVld && (prvTag_q == lookupTagA_i)) begin
            lookupA_o.hit  = 1'b1;
            lookupA_o.data = prvData_q;
        end
    end

    always_comb begin
        lookupB_o.hit  = 1'b0;
        lookupB_o.data = '0;
        if (curVld && (curTag_q == lookupTagB_i)) begin
            lookupB_o.hit  = 1'b1;
            lookupB_o.data = curData_q;
        end else if (prvVld && (prvTag_q == lookupTagB_i)) begin
            lookupB_o.hit  = 1'b1;
            lookupB_o.data = prvData_q;
        end
    end

endmodule

// File: rtl/fetch_align.sv
// fetch_align
// Fetch-stage instruction aligner. Buffers returned SRAM lines and extracts
// the 16/32-bit instruction at pc, including 32-bit instructions that straddle
// two lines. Extraction only looks at registered lines, so a captured line is
// usable the cycle after it returns.
// Ports:
//   clk, cpurst_n  : clock, async active-low reset
//   isram          : SRAM read-return bus (slave side)
//   pc             : current fetch pc (halfword aligned)
//   fet_kill       : redirect, invalidates the buffer
//   rv32_instr     : aligned instruction, compressed ones zero-extended
//   isrv16         : rv32_instr is compressed
//   instr_valid    : rv32_instr is real, not NOP filler
//   fetch_misalign : straddling instruction is waiting for its upper half
module fetch_align
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          cpurst_n,
    fetch_align_if.slave  isram,
    input  logic [31:0]   pc,
    input  logic          fet_kill,
    output logic [31:0]   rv32_instr,
    output logic          isrv16,
    output logic          instr_valid,
    output logic          fetch_misalign
);

    logic [LINE_AW-1:0]  loTag;
    logic [LINE_AW-1:0]  hiTag;
    logic [HW_IDX_W-1:0] hwIdx;
    lookupRes_t          loRes;
    lookupRes_t          hiRes;
    logic [15:0]         loHw;
    logic [15:0]         nextHw;
    logic [15:0]         hiHw;

    // The hi lookup wraps modulo 2^29, so the last line pairs with line 0
    assign loTag = pc[31:3];
    assign hiTag = loTag + {{(LINE_AW-1){1'b0}}, 1'b1};
    assign hwIdx = pc[2:1];

    fetch_line_buf u_lineBuf (
        .clk          (clk),
        .cpurst_n     (cpurst_n),
        .capEn_i      (isram.isram_cs_ff),
        .capTag_i     (isram.isram_rdata_adr),
        .capData_i    (isram.isram_rdata),
        .kill_i       (fet_kill),
        .lookupTagA_i (loTag),
        .lookupA_o    (loRes),
        .lookupTagB_i (hiTag),
        .lookupB_o    (hiRes)
    );

    // nextHw is only consumed when hwIdx < 3, so its wrap at 3 is harmless
    assign loHw   = getHalf(loRes.data, hwIdx);
    assign nextHw = getHalf(loRes.data, hwIdx + 2'd1);
    assign hiHw   = getHalf(hiRes.data, 2'd0);

    // Halfword mux: compressed, in-line 32-bit, or straddling 32-bit whose
    // upper half comes from the following line's halfword 0.
    always_comb begin
        rv32_instr     = NOP_INSTR;
        isrv16         = 1'b0;
        instr_valid    = 1'b0;
        fetch_misalign = 1'b0;
        if (loRes.hit) begin
            if (isRvc(loHw)) begin
                rv32_instr  = {16'h0000, loHw};
                isrv16      = 1'b1;
                instr_valid = 1'b1;
            end else if (hwIdx != 2'd3) begin
                rv32_instr  = {nextHw, loHw};
                instr_valid = 1'b1;
            end else if (hiRes.hit) begin
                rv32_instr  = {hiHw, loHw};
                instr_valid = 1'b1;
            end else begin
                fetch_misalign = 1'b1;
            end
        end
    end

    // Instructions are at least halfword aligned, so pc[0] must stay clear
    pcAlignChk: assert property (@(posedge clk) disable iff (!cpurst_n) pc[0] == 1'b0);

endmodule

// File: tb/tb_fetch_align.sv
// tb_fetch_align
// Table-driven bench for fetch_align with a scoreboard of expected outputs,
// plus hand sequences for same-cycle capture/straddle and async reset.
module tb_fetch_align;
    import fetch_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic        rvc;
        logic        vld;
        logic        mis;
    } expOut_t;

    typedef struct packed {
        logic        cs;
        logic        kill;
        logic [28:0] adr;
        logic [63:0] data;
        logic [31:0] pc;
        expOut_t     exp;
    } vec_t;

    logic        clk;
    logic        cpurst_n;
    logic [31:0] pc;
    logic        fet_kill;
    logic [31:0] rv32_instr;
    logic        isrv16;
    logic        instr_valid;
    logic        fetch_misalign;

    fetch_align_if isramBus ();

    fetch_align dut (
        .clk            (clk),
        .cpurst_n       (cpurst_n),
        .isram          (isramBus),
        .pc             (pc),
        .fet_kill       (fet_kill),
        .rv32_instr     (rv32_instr),
        .isrv16         (isrv16),
        .instr_valid    (instr_valid),
        .fetch_misalign (fetch_misalign)
    );

    int      checksRun    = 0;
    int      checksPassed = 0;
    expOut_t sbQ[$];
    vec_t    vecs[$];

    localparam expOut_t NOP_OUT = '{instr: 32'h00000013, rvc: 1'b0, vld: 1'b0, mis: 1'b0};

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bounded run time
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic expOut_t mkExp(input logic [31:0] instr, input logic rvc,
                                      input logic vld, input logic mis);
        expOut_t e;
        e.instr = instr;
        e.rvc   = rvc;
        e.vld   = vld;
        e.mis   = mis;
        return e;
    endfunction

    task automatic addVec(input logic cs, input logic kill, input logic [28:0] adr,
                          input logic [63:0] data, input logic [31:0] pcVal,
                          input expOut_t e);
        vec_t v;
        v.cs   = cs;
        v.kill = kill;
        v.adr  = adr;
        v.data = data;
        v.pc   = pcVal;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now
    task automatic checkOutput(input string name);
        expOut_t e;
        expOut_t a;
        checksRun++;
        a = {rv32_instr, isrv16, instr_valid, fetch_misalign};
        if (sbQ.size() == 0) begin
            $display("[TB] FAIL %s: scoreboard empty, got instr=%h rvc=%b vld=%b mis=%b",
                     name, a.instr, a.rvc, a.vld, a.mis);
        end else begin
            e = sbQ.pop_front();
            if (a === e) begin
                checksPassed++;
            end else begin
                $display("[TB] FAIL %s: got instr=%h rvc=%b vld=%b mis=%b, want instr=%h rvc=%b vld=%b mis=%b",
                         name, a.instr, a.rvc, a.vld, a.mis, e.instr, e.rvc, e.vld, e.mis);
            end
        end
    endtask

    // Drive one vector for a cycle, then check the post-capture outputs
    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        isramBus.isram_cs_ff     = v.cs;
        isramBus.isram_rdata_adr = v.adr;
        isramBus.isram_rdata     = v.data;
        fet_kill                 = v.kill;
        pc                       = v.pc;
        sbQ.push_back(v.exp);
        @(negedge clk);
        isramBus.isram_cs_ff = 1'b0;
        fet_kill             = 1'b0;
        checkOutput(name);
    endtask

    initial begin
        vec_t v;

        cpurst_n                 = 1'b0;
        fet_kill                 = 1'b0;
        pc                       = 32'h80;
        isramBus.isram_cs_ff     = 1'b0;
        isramBus.isram_rdata     = '0;
        isramBus.isram_rdata_adr = '0;

        // Sequential table: each row sees the buffer left by the rows before
        addVec(0, 0, 29'h10, 64'h0, 32'h80, NOP_OUT);
        addVec(1, 0, 29'h10, 64'h00A00093_00100513, 32'h80, mkExp(32'h00100513, 0, 1, 0));
        addVec(0, 0, 29'h0, 64'h0, 32'h84, mkExp(32'h00A00093, 0, 1, 0));
        addVec(0, 0, 29'h0, 64'h0, 32'h82, mkExp(32'h00000010, 1, 1, 0));
        addVec(0, 0, 29'h0, 64'h0, 32'h88, NOP_OUT);
        addVec(1, 0, 29'h10, 64'h0513_4505_0001_0001, 32'h84, mkExp(32'h00004505, 1, 1, 0));
        addVec(0, 0, 29'h0, 64'h0, 32'h86, mkExp(32'h00000013, 0, 0, 1));
        addVec(1, 0, 29'h11, 64'h1111_2222_3333_0010, 32'h86, mkExp(32'h00100513, 0, 1, 0));
        addVec(0, 0, 29'h0, 64'h0, 32'h80, mkExp(32'h00000001, 1, 1, 0));
        addVec(0, 0, 29'h0, 64'h0, 32'h88, mkExp(32'h00000010, 1, 1, 0));
        addVec(1, 0, 29'h11, 64'hABCD_00A0_0093_4501, 32'h8A, mkExp(32'h00A00093, 0, 1, 0));
        addVec(0, 0, 29'h0, 64'h0, 32'h86, mkExp(32'h45010513, 0, 1, 0));
        addVec(1, 0, 29'h20, 64'h0000_0000_0000_4111, 32'h100, mkExp(32'h00004111, 1, 1, 0));
        addVec(0, 0, 29'h0, 64'h0, 32'h80, NOP_OUT);
        addVec(0, 0, 29'h0, 64'h0, 32'h88, mkExp(32'h00004501, 1, 1, 0));
        addVec(1, 1, 29'h30, 64'h0000_0000_0000_0001, 32'h180, NOP_OUT);
        addVec(0, 0, 29'h0, 64'h0, 32'h88, NOP_OUT);
        addVec(1, 0, 29'h1FFFFFFF, 64'h0513_0000_0000_0000, 32'hFFFFFFFE, mkExp(32'h00000013, 0, 0, 1));
        addVec(1, 0, 29'h0, 64'h0000_0000_0000_00A0, 32'hFFFFFFFE, mkExp(32'h00A00513, 0, 1, 0));
        addVec(0, 0, 29'h0, 64'h0, 32'h0, mkExp(32'h000000A0, 1, 1, 0));

        // Reset state
        repeat (2) @(negedge clk);
        sbQ.push_back(NOP_OUT);
        checkOutput("resetState");
        cpurst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Capture of the hi line in the same cycle as the straddle lookup:
        // still misaligned before the edge, resolved the cycle after
        v = '0;
        v.kill = 1'b1;
        v.pc   = 32'h86;
        v.exp  = NOP_OUT;
        applyStimulus(v, "killClear");
        v = '0;
        v.cs   = 1'b1;
        v.adr  = 29'h10;
        v.data = 64'h0513_4505_0001_0001;
        v.pc   = 32'h86;
        v.exp  = mkExp(32'h00000013, 0, 0, 1);
        applyStimulus(v, "straddleLoOnly");
        @(negedge clk);
        isramBus.isram_cs_ff     = 1'b1;
        isramBus.isram_rdata_adr = 29'h11;
        isramBus.isram_rdata     = 64'h1111_2222_3333_0010;
        #1;
        sbQ.push_back(mkExp(32'h00000013, 0, 0, 1));
        checkOutput("preEdgeStraddle");
        @(negedge clk);
        isramBus.isram_cs_ff = 1'b0;
        sbQ.push_back(mkExp(32'h00100513, 0, 1, 0));
        checkOutput("postEdgeStraddle");

        // Async reset mid-run with both entries valid
        @(negedge clk);
        pc = 32'h80;
        #1;
        sbQ.push_back(mkExp(32'h00000001, 1, 1, 0));
        checkOutput("prvBeforeReset");
        cpurst_n = 1'b0;
        #1;
        sbQ.push_back(NOP_OUT);
        checkOutput("asyncReset");
        @(negedge clk);
        cpurst_n = 1'b1;
        @(negedge clk);
        sbQ.push_back(NOP_OUT);
        checkOutput("postResetEmpty");
        v = '0;
        v.cs   = 1'b1;
        v.adr  = 29'h10;
        v.data = 64'h0513_4505_0001_0001;
        v.pc   = 32'h84;
        v.exp  = mkExp(32'h00004505, 1, 1, 0);
        applyStimulus(v, "captureAfterReset");
        v = '0;
        v.pc   = 32'h86;
        v.exp  = mkExp(32'h00000013, 0, 0, 1);
        applyStimulus(v, "noStalePrv");

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
